// File: rtl/dac_spi_master_pkg.sv
// Shared types and frame layout for the MCP4911-class DAC SPI master.
// Frame is {AB, BUF, GA_N, SHDN_N, sample[9:0], 2'b00}, MSB first.
package dac_pkg;

  localparam int DAC_FRAME_W  = 16;
  localparam int DAC_SAMPLE_W = 10;

  localparam int BIT_AB       = 15;
  localparam int BIT_BUF      = 14;
  localparam int BIT_GA_N     = 13;
  localparam int BIT_SHDN_N   = 12;
  localparam int BIT_DATA_LSB = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP,
    LDAC
  } dac_state_t;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame(
    input logic                    buf_bit,
    input logic                    ga_n_bit,
    input logic                    shdn_n_bit,
    input logic [DAC_SAMPLE_W-1:0] sample
  );
    logic [DAC_FRAME_W-1:0] f;
    f                                = '0;
    f[BIT_AB]                        = 1'b0;
    f[BIT_BUF]                       = buf_bit;
    f[BIT_GA_N]                      = ga_n_bit;
    f[BIT_SHDN_N]                    = shdn_n_bit;
    f[BIT_DATA_LSB +: DAC_SAMPLE_W]  = sample;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_master_if.sv
// Sample handshake plus DAC pin bundle; master modport is the SPI master side.
interface dac_spi_master_if;

  logic                             in_valid;
  logic [dac_pkg::DAC_SAMPLE_W-1:0] in_sample;
  logic                             in_enable;
  logic                             in_ready;
  logic                             done;
  logic                             sck;
  logic                             mosi;
  logic                             cs_n;
  logic                             ldac_n;

  modport master (
    input  in_valid, in_sample, in_enable,
    output in_ready, done, sck, mosi, cs_n, ldac_n
  );

  modport slave (
    output in_valid, in_sample, in_enable,
    input  in_ready, done, sck, mosi, cs_n, ldac_n
  );

endinterface

// File: rtl/dac_spi_master_sck_tick_gen.sv
// Divider for the SPI master: counts 0..CLK_DIV-1 and pulses tick on the
// terminal count. Held at zero while clear is high so every frame starts aligned.
module sck_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = !clear && (div_cnt == TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_master.sv
// Mode-0 SPI master sending one 16-bit DAC command per accepted sample.
// Optional LDAC latch pulse after each frame when DAC_SPI_LDAC_PULSE_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, cs_n high, waiting for a sample
// SHIFT | 16 bits out, sck low half then high half per bit
// HOLD  | cs_n still low, sck/mosi low, cs hold time
// GAP   | cs_n high, minimum deselect time
// LDAC  | ldac_n low pulse (optional build only)
module dac_spi_master
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter bit BUF     = 1'b0,
  parameter bit GA_N    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  dac_spi_master_if.master bus
);

  dac_state_t             state, state_d;
  logic [3:0]             bit_cnt, bit_cnt_d;
  logic                   phase, phase_d;
  logic [DAC_FRAME_W-1:0] shreg, shreg_d;
  logic                   sck_q, sck_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_n_q, cs_n_d;
  logic                   ldac_n_q, ldac_n_d;
  logic                   in_ready_q, in_ready_d;
  logic                   done_q, done_d;
  logic                   tick;
  logic                   accept;
  logic [DAC_FRAME_W-1:0] frame;

  sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign frame  = dac_frame(BUF, GA_N, bus.in_enable, bus.in_sample);

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    phase_d    = phase;
    shreg_d    = shreg;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
`ifdef DAC_SPI_LDAC_PULSE_EN
    ldac_n_d   = ldac_n_q;
`else
    // Without the pulse the DAC latches on cs_n rising, so LDAC is tied active.
    ldac_n_d   = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          state_d    = SHIFT;
          shreg_d    = frame;
          mosi_d     = frame[DAC_FRAME_W-1];
          cs_n_d     = 1'b0;
          sck_d      = 1'b0;
          phase_d    = 1'b0;
          bit_cnt_d  = 4'd0;
          in_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase) begin
            sck_d   = 1'b1;
            phase_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            phase_d = 1'b0;
            if (bit_cnt == 4'd15) begin
              state_d   = HOLD;
              bit_cnt_d = 4'd0;
              mosi_d    = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt + 4'd1;
              shreg_d   = shreg << 1;
              mosi_d    = shreg[DAC_FRAME_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
`ifdef DAC_SPI_LDAC_PULSE_EN
          state_d    = LDAC;
          ldac_n_d   = 1'b0;
`else
          state_d    = IDLE;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
`endif
        end
      end
`ifdef DAC_SPI_LDAC_PULSE_EN
      LDAC: begin
        if (tick) begin
          state_d    = IDLE;
          ldac_n_d   = 1'b1;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d    = IDLE;
        cs_n_d     = 1'b1;
        sck_d      = 1'b0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      phase      <= 1'b0;
      shreg      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= 1'b1;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      phase      <= phase_d;
      shreg      <= shreg_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      ldac_n_q   <= ldac_n_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.ldac_n   = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_master.sv
// Directed bench for dac_spi_master: default-parameter instance (CLK_DIV=4)
// and a CLK_DIV=1, BUF=1, GA_N=0 instance, observed by per-instance monitors.
module tb_dac_spi_master;
  import dac_pkg::*;

`ifdef DAC_SPI_LDAC_PULSE_EN
  localparam int PER_A = 141;
  localparam int PER_B = 36;
`else
  localparam int PER_A = 137;
  localparam int PER_B = 35;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  dac_spi_master_if ia();
  dac_spi_master_if ib();

  dac_spi_master dut_a (.clk(clk), .reset(rst_a), .bus(ia.master));
  dac_spi_master #(.CLK_DIV(1), .BUF(1'b1), .GA_N(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ib.master));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // monitors, sampled on the falling edge
  int cyc = 0;
  logic        a_psck = 1'b0, a_pmosi = 1'b0, a_pcs = 1'b1;
  logic [15:0] a_cap = '0;
  logic [15:0] a_fr [0:7];
  int          a_frn = 0, a_rises = 0, a_cslow = 0, a_done = 0, a_unstab = 0;
  int          a_ldlow = 0, a_ldhi = 0, a_accn = 0;
  int          a_acc_cyc [0:7];
  logic        b_psck = 1'b0, b_pmosi = 1'b0, b_pcs = 1'b1;
  logic [15:0] b_cap = '0;
  logic [15:0] b_fr [0:7];
  int          b_frn = 0, b_rises = 0, b_cslow = 0, b_unstab = 0;

  always @(negedge clk) begin
    cyc++;
    if (ia.sck && !a_psck) begin a_cap = {a_cap[14:0], ia.mosi}; a_rises++; end
    if (ia.sck && (ia.mosi !== a_pmosi)) a_unstab++;
    if (!ia.cs_n) a_cslow++;
    if (ia.cs_n && !a_pcs) begin a_fr[a_frn & 7] = a_cap; a_frn++; end
    if (ia.done) a_done++;
    if (ia.ldac_n === 1'b0) a_ldlow++;
    if (ia.ldac_n === 1'b1 && !rst_a) a_ldhi++;
    if (ia.in_valid && ia.in_ready && !rst_a) begin a_acc_cyc[a_accn & 7] = cyc; a_accn++; end
    a_psck = ia.sck; a_pmosi = ia.mosi; a_pcs = ia.cs_n;

    if (ib.sck && !b_psck) begin b_cap = {b_cap[14:0], ib.mosi}; b_rises++; end
    if (ib.sck && (ib.mosi !== b_pmosi)) b_unstab++;
    if (!ib.cs_n) b_cslow++;
    if (ib.cs_n && !b_pcs) begin b_fr[b_frn & 7] = b_cap; b_frn++; end
    b_psck = ib.sck; b_pmosi = ib.mosi; b_pcs = ib.cs_n;
  end

  task automatic send_a(input logic [9:0] s, input logic en);
    int n = 0;
    @(posedge clk); #1;
    ia.in_valid = 1'b1; ia.in_sample = s; ia.in_enable = en;
    while (n < 400) begin
      @(negedge clk);
      if (ia.in_ready) break;
      n++;
    end
    chk("accept_a", n < 400, 1'b1);
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ia.in_sample = 10'($urandom); ia.in_enable = 1'($urandom);
  endtask

  task automatic send_b(input logic [9:0] s, input logic en);
    int n = 0;
    @(posedge clk); #1;
    ib.in_valid = 1'b1; ib.in_sample = s; ib.in_enable = en;
    while (n < 400) begin
      @(negedge clk);
      if (ib.in_ready) break;
      n++;
    end
    chk("accept_b", n < 400, 1'b1);
    @(posedge clk); #1;
    ib.in_valid = 1'b0; ib.in_sample = 10'($urandom); ib.in_enable = 1'($urandom);
  endtask

  task automatic wait_done_a(input int start, input int max, output int n);
    n = start;
    while (!ia.done && n < max) begin @(negedge clk); n++; end
  endtask

  task automatic wait_done_b(input int start, input int max, output int n);
    n = start;
    while (!ib.done && n < max) begin @(negedge clk); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s_rises, s_cslow, s_done, s_unstab, s_ldlow, s_ldhi, s_accn, s_frn;
    logic [9:0] v;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.in_valid = 1'b0; ia.in_sample = '0; ia.in_enable = 1'b0;
    ib.in_valid = 1'b0; ib.in_sample = '0; ib.in_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ia.in_ready, 1'b1);
    chk("rst_done",     ia.done,     1'b0);
    chk("rst_sck",      ia.sck,      1'b0);
    chk("rst_mosi",     ia.mosi,     1'b0);
    chk("rst_cs_n",     ia.cs_n,     1'b1);
    chk("rst_ldac_n",   ia.ldac_n,   1'b1);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
`ifndef DAC_SPI_LDAC_PULSE_EN
    chk("ldac_tied_low", ia.ldac_n, 1'b0);
`endif

    // frame 1: 0x2A5, enable=1 -> 0x3A94
    s_rises = a_rises; s_cslow = a_cslow; s_done = a_done; s_unstab = a_unstab;
    s_ldlow = a_ldlow; s_ldhi = a_ldhi;
    send_a(10'h2A5, 1'b1);
    @(negedge clk);
    chk("first_in_ready", ia.in_ready, 1'b0);
    chk("first_cs_n",     ia.cs_n,     1'b0);
    chk("first_sck",      ia.sck,      1'b0);
    wait_done_a(1, 400, n);
    chk("a1_done_latency", n, PER_A);
    chk("a1_in_ready_on_done", ia.in_ready, 1'b1);
    @(negedge clk);
    chk("a1_done_width", ia.done, 1'b0);
    chk("a1_frame", a_fr[(a_frn - 1) & 7], 16'h3A94);
    chk("a1_rises", a_rises - s_rises, 16);
    chk("a1_cs_low", a_cslow - s_cslow, 132);
    chk("a1_done_count", a_done - s_done, 1);
    chk("a1_mosi_stable", a_unstab - s_unstab, 0);
`ifdef DAC_SPI_LDAC_PULSE_EN
    chk("a1_ldac_low", a_ldlow - s_ldlow, 4);
`else
    chk("a1_ldac_high", a_ldhi - s_ldhi, 0);
`endif

    // CLK_DIV=1 instance, BUF=1 GA_N=0
    s_rises = b_rises; s_cslow = b_cslow; s_unstab = b_unstab;
    send_b(10'h3FF, 1'b0);
    wait_done_b(0, 200, n);
    chk("b1_done_latency", n, PER_B);
    chk("b1_frame", b_fr[(b_frn - 1) & 7], 16'h4FFC);
    chk("b1_rises", b_rises - s_rises, 16);
    chk("b1_cs_low", b_cslow - s_cslow, 33);
    chk("b1_mosi_stable", b_unstab - s_unstab, 0);
    @(negedge clk);
    send_b(10'h001, 1'b1);
    wait_done_b(0, 200, n);
    chk("b2_done_latency", n, PER_B);
    chk("b2_frame", b_fr[(b_frn - 1) & 7], 16'h5004);

    // back-to-back with in_valid held and sample changing every cycle
    s_accn = a_accn; s_frn = a_frn; s_ldlow = a_ldlow; s_ldhi = a_ldhi; s_unstab = a_unstab;
    @(posedge clk); #1;
    ia.in_valid = 1'b1; ia.in_enable = 1'b1;
    for (int i = 0; i < 3 * PER_A + 5; i++) begin
      ia.in_sample = 10'(i * 37 + 5);
      @(posedge clk); #1;
    end
    ia.in_valid = 1'b0;
    wait_done_a(0, PER_A + 10, n);
    @(negedge clk);
    chk("b2b_accepts", a_accn - s_accn, 4);
    chk("b2b_frames", a_frn - s_frn, 4);
    for (int k = 0; k < 3; k++)
      chk("b2b_period", a_acc_cyc[(s_accn + k + 1) & 7] - a_acc_cyc[(s_accn + k) & 7], PER_A);
    for (int k = 0; k < 4; k++) begin
      v = 10'(k * PER_A * 37 + 5);
      chk("b2b_frame", a_fr[(s_frn + k) & 7], {4'b0011, v, 2'b00});
    end
    chk("b2b_mosi_stable", a_unstab - s_unstab, 0);
`ifdef DAC_SPI_LDAC_PULSE_EN
    chk("b2b_ldac_low", a_ldlow - s_ldlow, 16);
`else
    chk("b2b_ldac_high", a_ldhi - s_ldhi, 0);
`endif

    // reset 40 cycles into a frame, then a clean frame
    s_done = a_done;
    send_a(10'h1C3, 1'b1);
    repeat (40) @(negedge clk);
    chk("mid_cs_n_before", ia.cs_n, 1'b0);
    #1 rst_a = 1'b1;
    #1;
    chk("abort_cs_n", ia.cs_n, 1'b1);
    chk("abort_sck",  ia.sck,  1'b0);
    chk("abort_mosi", ia.mosi, 1'b0);
    chk("abort_in_ready", ia.in_ready, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_a = 1'b0;
    chk("abort_no_done", a_done - s_done, 0);
    send_a(10'h155, 1'b1);
    wait_done_a(0, 400, n);
    chk("post_abort_latency", n, PER_A);
    @(negedge clk);
    chk("post_abort_frame", a_fr[(a_frn - 1) & 7], 16'h3554);
    chk("post_abort_done_count", a_done - s_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
